delay_line_param: RTL

Parametrised, runtime-programmable delay line for aligning data paths in the CORDIC FFT pipeline, e.g. the twiddle/data path skew between butterfly stages. It generalises the fixed 32-bit, 23-cycle delay to:
- configurable width and maximum depth
- a depth that can be reloaded at run time
- clock-enable stall
- a valid tag carried alongside the data
- a primed indication showing the line holds a full depth of fresh samples

---
 rtl/delay_line_param.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/delay_line_param.sv
// delay_line_param
// ----------------
// Runtime-programmable delay line used to line up data paths in the CORDIC
// FFT pipeline (e.g. twiddle/data skew between butterfly stages).
//
// A sample accepted on an enabled edge appears on o_data/o_valid exactly D
// enabled edges later (the D-th edge inclusive), where D is the depth in
// effect. Disabled cycles (i_en=0) freeze the whole line, including outputs
// and the fill counter.
//
// Optional feature: define DELAY_LINE_FLUSH_EN to add the synchronous
// i_flush input, which empties the line and restarts the fill count.
//
// Parameters:
//   WIDTH       data word width
//   MAX_DEPTH   largest selectable delay (>= 2)
//   DEPTH_W     width of depth ports (2**DEPTH_W > MAX_DEPTH)
//   RESET_DEPTH delay in effect after reset (1..MAX_DEPTH)
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_en         advance enable (0 = hold everything)
//   i_flush      synchronous flush (only with DELAY_LINE_FLUSH_EN)
//   i_valid      valid tag travelling with i_data
//   i_data       input sample
//   i_depth      new delay value, clamped to 1..MAX_DEPTH when loaded
//   i_depth_load load strobe for i_depth, honoured regardless of i_en
//   o_data       delayed sample (registered)
//   o_valid      delayed valid tag (registered)
//   o_depth      depth currently in effect
//   o_primed     high once D enabled shifts completed since reset/load/flush
//
// Handshake: there is no back-pressure. i_valid is a tag, not a request;
// every enabled edge consumes one {i_valid, i_data} pair and produces one
// {o_valid, o_data} pair. Consumers qualify output with o_valid/o_primed.

module delay_line_param #(
  parameter int WIDTH       = 32,
  parameter int MAX_DEPTH   = 32,
  parameter int DEPTH_W     = 6,
  parameter int RESET_DEPTH = 23
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
`ifdef DELAY_LINE_FLUSH_EN
  input  logic               i_flush,
`endif
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [DEPTH_W-1:0] i_depth,
  input  logic               i_depth_load,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_valid,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_primed
);

  // Elaboration-time parameter sanity checks.
  if (MAX_DEPTH < 2) begin : g_bad_max_depth
    $error("delay_line_param: MAX_DEPTH must be >= 2");
  end
  if ((64'd1 << DEPTH_W) <= 64'(MAX_DEPTH)) begin : g_bad_depth_w
    $error("delay_line_param: DEPTH_W too narrow for MAX_DEPTH");
  end
  if (RESET_DEPTH < 1 || RESET_DEPTH > MAX_DEPTH) begin : g_bad_reset_depth
    $error("delay_line_param: RESET_DEPTH out of range");
  end

  localparam logic [DEPTH_W-1:0] MAX_D   = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] RESET_D = DEPTH_W'(RESET_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_D   = DEPTH_W'(1);

  // Fill tracking FSM: FILL counts enabled edges up to D, PRIMED saturates.
  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_PRIMED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   stage_data_q  [1:MAX_DEPTH-1];
  logic [WIDTH-1:0]   stage_data_d  [1:MAX_DEPTH-1];
  logic               stage_valid_q [1:MAX_DEPTH-1];
  logic               stage_valid_d [1:MAX_DEPTH-1];

  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   tap_data;
  logic               tap_valid;
  logic               flush;

`ifdef DELAY_LINE_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Output tap for the depth currently in effect. D=1 bypasses the stages;
  // otherwise stage[D-1] feeds the output register so the total is D edges.
  always_comb begin
    tap_data  = i_data;
    tap_valid = i_valid;
    for (int k = 1; k < MAX_DEPTH; k++) begin
      if (depth_q == DEPTH_W'(k + 1)) begin
        tap_data  = stage_data_q[k];
        tap_valid = stage_valid_q[k];
      end
    end
  end

  // Datapath next-state: flush beats enable; enable shifts the whole line.
  always_comb begin
    stage_data_d  = stage_data_q;
    stage_valid_d = stage_valid_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;

    if (flush) begin
      for (int k = 1; k < MAX_DEPTH; k++) begin
        stage_data_d[k]  = '0;
        stage_valid_d[k] = 1'b0;
      end
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else if (i_en) begin
      stage_data_d[1]  = i_data;
      stage_valid_d[1] = i_valid;
      for (int k = 2; k < MAX_DEPTH; k++) begin
        stage_data_d[k]  = stage_data_q[k-1];
        stage_valid_d[k] = stage_valid_q[k-1];
      end
      out_data_d  = tap_data;
      out_valid_d = tap_valid;
    end
  end

  // Depth register with clamping into 1..MAX_DEPTH. The tap above reads
  // depth_q, so a shift on the load edge still uses the old depth.
  always_comb begin
    depth_d = depth_q;
    if (i_depth_load) begin
      if (i_depth == '0) begin
        depth_d = ONE_D;
      end else if (i_depth > MAX_D) begin
        depth_d = MAX_D;
      end else begin
        depth_d = i_depth;
      end
    end
  end

  // Fill FSM next-state. A load or flush restarts counting from zero and the
  // shift on that edge is deliberately not counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_depth_load || flush) begin
      state_d = ST_FILL;
      cnt_d   = '0;
    end else if (i_en) begin
      case (state_q)
        ST_FILL: begin
          cnt_d = cnt_q + ONE_D;
          if ((cnt_q + ONE_D) == depth_q) begin
            state_d = ST_PRIMED;
          end
        end
        ST_PRIMED: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 1; k < MAX_DEPTH; k++) begin
        stage_data_q[k]  <= '0;
        stage_valid_q[k] <= 1'b0;
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      depth_q     <= RESET_D;
      cnt_q       <= '0;
      state_q     <= ST_FILL;
    end else begin
      stage_data_q  <= stage_data_d;
      stage_valid_q <= stage_valid_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      depth_q       <= depth_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
    end
  end

  assign o_data   = out_data_q;
  assign o_valid  = out_valid_q;
  assign o_depth  = depth_q;
  assign o_primed = (state_q == ST_PRIMED);

endmodule
